// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, group advance, per-slot PCs/valids,
// and buffering of redirects that arrive while fetch is stalled.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   stall_i               hold the PC this cycle
//   redirect_valid_i/pc_i redirect request and target
//   pc_o                  registered fetch PC
//   slot_pc_o             slot i PC in [i*WIDTH +: WIDTH]
//   slot_valid_o          lanes at or after the PC within its group
//   fetch_valid_o         current group is consumed by fetch
//   redirect_pending_o    a buffered redirect is waiting
module fetch_pc_gen #(
  parameter int WIDTH       = 32,
  parameter int RESET_PC    = 4,
  parameter int FETCH_WIDTH = 2,
  parameter int INSTR_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_i,
  input  logic                         redirect_valid_i,
  input  logic [WIDTH-1:0]             redirect_pc_i,
  output logic [WIDTH-1:0]             pc_o,
  output logic [FETCH_WIDTH*WIDTH-1:0] slot_pc_o,
  output logic [FETCH_WIDTH-1:0]       slot_valid_o,
  output logic                         fetch_valid_o,
  output logic                         redirect_pending_o
);

  localparam int G  = FETCH_WIDTH * INSTR_BYTES;
  localparam int IB = $clog2(INSTR_BYTES);

  localparam logic [WIDTH-1:0] GRP_SZ = WIDTH'(G);
  localparam logic [WIDTH-1:0] GRP_MK = ~(WIDTH'(G) - 1'b1);
  localparam logic [WIDTH-1:0] INS_MK = ~(WIDTH'(INSTR_BYTES) - 1'b1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pend_nxt;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_next_grp;
  logic [WIDTH-1:0] w_off;

  assign w_tgt      = redirect_pc_i & INS_MK;
  assign w_next_grp = (r_pc & GRP_MK) + GRP_SZ;
  // lane index of the PC inside its aligned group
  assign w_off      = (r_pc >> IB) % WIDTH'(FETCH_WIDTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_BOOT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= WIDTH'(RESET_PC);
      r_pend <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    unique case (r_state)
      S_BOOT: begin
        if (redirect_valid_i) begin
          w_pend_nxt  = w_tgt;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall_i) begin
          w_pc_nxt = redirect_valid_i ? w_tgt : w_next_grp;
        end else if (redirect_valid_i) begin
          w_pend_nxt  = w_tgt;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stall_i) begin
          if (redirect_valid_i) w_pend_nxt = w_tgt;
        end else begin
          // a live redirect is younger than the buffered one
          w_pc_nxt    = redirect_valid_i ? w_tgt : r_pend;
          w_pend_nxt  = '0;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    pc_o               = r_pc;
    fetch_valid_o      = (r_state == S_RUN) && !stall_i;
    redirect_pending_o = (r_state == S_HOLD);
    slot_pc_o          = '0;
    slot_valid_o       = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_pc_o[i*WIDTH +: WIDTH] = r_pc + WIDTH'(i * INSTR_BYTES);
      slot_valid_o[i] = WIDTH'(i) < (WIDTH'(FETCH_WIDTH) - w_off);
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vectors for fetch_pc_gen
// (W=32, RESET_PC=4, FETCH_WIDTH=2, INSTR_BYTES=4).
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [63:0] slot_pc_o;
  logic [1:0]  slot_valid_o;
  logic        fetch_valid_o;
  logic        redirect_pending_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_pc_gen #(
    .WIDTH(32),
    .RESET_PC(4),
    .FETCH_WIDTH(2),
    .INSTR_BYTES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .pc_o(pc_o),
    .slot_pc_o(slot_pc_o),
    .slot_valid_o(slot_valid_o),
    .fetch_valid_o(fetch_valid_o),
    .redirect_pending_o(redirect_pending_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic v, input logic [31:0] pc);
    redirect_valid_i = v;
    redirect_pc_i    = pc;
  endtask

  initial begin
    reset = 1'b1;
    stall_i = 1'b0;
    redir(1'b0, 32'h0);
    #3;
    chk("rst_pc", pc_o, 32'd4);
    chk("rst_fv", 32'(fetch_valid_o), 32'd0);
    chk("rst_pend", 32'(redirect_pending_o), 32'd0);
    chk("rst_sv", 32'(slot_valid_o), 32'b01);
    chk("rst_s0", slot_pc_o[31:0], 32'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_fv", 32'(fetch_valid_o), 32'd0);

    // 1: free run 4, 8, 16, 24
    step;
    chk("t1_pc4", pc_o, 32'd4);
    chk("t1_fv", 32'(fetch_valid_o), 32'd1);
    chk("t1_sv4", 32'(slot_valid_o), 32'b01);
    chk("t1_s0_4", slot_pc_o[31:0], 32'd4);
    step;
    chk("t1_pc8", pc_o, 32'd8);
    chk("t1_sv8", 32'(slot_valid_o), 32'b11);
    chk("t1_s0_8", slot_pc_o[31:0], 32'd8);
    chk("t1_s1_8", slot_pc_o[63:32], 32'd12);
    step;
    chk("t1_pc16", pc_o, 32'd16);

    // 2: stall 3 cycles at 16
    stall_i = 1'b1;
    #1;
    chk("t2_fv0", 32'(fetch_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("t2_pc", pc_o, 32'd16);
      chk("t2_fv", 32'(fetch_valid_o), 32'd0);
    end
    stall_i = 1'b0;
    #1;
    chk("t2_rel_fv", 32'(fetch_valid_o), 32'd1);
    step;
    chk("t2_pc24", pc_o, 32'd24);

    // 3: unstalled redirect, low bits dropped
    redir(1'b1, 32'h103);
    #1;
    chk("t3_fv_rd", 32'(fetch_valid_o), 32'd1);
    step;
    chk("t3_pc", pc_o, 32'h100);
    chk("t3_fv", 32'(fetch_valid_o), 32'd1);
    redir(1'b0, 32'h0);
    step;
    chk("t3_pc2", pc_o, 32'h108);
    chk("t3_fv2", 32'(fetch_valid_o), 32'd1);

    // 4a: stalled redirects, latest wins, release without live one
    stall_i = 1'b1;
    redir(1'b1, 32'h204);
    step;
    chk("t4_pend", 32'(redirect_pending_o), 32'd1);
    chk("t4_hold_pc", pc_o, 32'h108);
    redir(1'b1, 32'h300);
    step;
    redir(1'b0, 32'h0);
    step;
    chk("t4_pend2", 32'(redirect_pending_o), 32'd1);
    chk("t4_hold_fv", 32'(fetch_valid_o), 32'd0);
    stall_i = 1'b0;
    #1;
    chk("t4_rel_fv", 32'(fetch_valid_o), 32'd0);
    step;
    chk("t4_pc300", pc_o, 32'h300);
    chk("t4_run_fv", 32'(fetch_valid_o), 32'd1);
    chk("t4_clr", 32'(redirect_pending_o), 32'd0);

    // 4b: live redirect on release beats pending
    stall_i = 1'b1;
    redir(1'b1, 32'h204);
    step;
    redir(1'b1, 32'h300);
    step;
    redir(1'b0, 32'h0);
    step;
    stall_i = 1'b0;
    redir(1'b1, 32'h400);
    #1;
    chk("t4b_rel_fv", 32'(fetch_valid_o), 32'd0);
    step;
    redir(1'b0, 32'h0);
    chk("t4b_pc400", pc_o, 32'h400);
    chk("t4b_pend", 32'(redirect_pending_o), 32'd0);

    // 5: wrap at top of address space
    redir(1'b1, 32'hFFFF_FFF8);
    step;
    redir(1'b0, 32'h0);
    chk("t5_pc", pc_o, 32'hFFFF_FFF8);
    chk("t5_s0", slot_pc_o[31:0], 32'hFFFF_FFF8);
    chk("t5_s1", slot_pc_o[63:32], 32'hFFFF_FFFC);
    chk("t5_sv", 32'(slot_valid_o), 32'b11);
    step;
    chk("t5_wrap", pc_o, 32'h0);

    // 6: async reset in HOLD discards pending
    stall_i = 1'b1;
    redir(1'b1, 32'h300);
    step;
    redir(1'b0, 32'h0);
    step;
    chk("t6_pend", 32'(redirect_pending_o), 32'd1);
    #2;
    reset = 1'b1;
    stall_i = 1'b0;
    #1;
    chk("t6_pc", pc_o, 32'd4);
    chk("t6_pend0", 32'(redirect_pending_o), 32'd0);
    chk("t6_fv", 32'(fetch_valid_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step;
    chk("t6_boot_pc", pc_o, 32'd4);
    chk("t6_run_fv", 32'(fetch_valid_o), 32'd1);
    step;
    chk("t6_pc8", pc_o, 32'd8);
    step;
    chk("t6_pc16", pc_o, 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
